// File: rtl/wb_ram_pkg.sv
// Shared types and constants for the Wishbone RAM bank controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_ram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_ACK  = 3'd3,
        ST_ERR  = 3'd4
    } wb_ram_state_e;

    // Fixed bank assignment on the core's memory map
    localparam int unsigned DRAM_BANK          = 0;
    localparam int unsigned IRAM_BANK          = 1;
    localparam int unsigned DEF_BANK_SEL_LSB   = 13;
    localparam int unsigned DEF_BANK_SEL_WIDTH = 4;

    // A decoded bank number is mapped only if a physical bank exists for it
    function automatic logic bank_valid(input logic [31:0] bank, input int unsigned num_banks);
        return (bank < num_banks);
    endfunction

endpackage

// File: rtl/wb_ram_bank_ctrl.sv
// Wishbone classic slave fanning one port out to NUM_BANKS single-port sync RAMs.
// Latency: write ack at cycle 2, read ack at 2+RD_LATENCY, error at cycle 1.
// Backpressure: one transfer in flight; master holds stb/cyc until ack/err.
module wb_ram_bank_ctrl
    import wb_ram_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 11,
    parameter int unsigned NUM_BANKS      = 2,
    parameter int unsigned BANK_SEL_LSB   = DEF_BANK_SEL_LSB,
    parameter int unsigned BANK_SEL_WIDTH = DEF_BANK_SEL_WIDTH,
    parameter int unsigned RD_LATENCY     = 1
) (
    input  logic                            wb_clk_i,
    input  logic                            rst_ni,
    input  logic                            en_i,
    input  logic [WB_ADDR_WIDTH-1:0]        wb_addr_i,
    input  logic [DATA_WIDTH-1:0]           wb_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]         wb_sel_i,
    input  logic                            wb_we_i,
    input  logic                            wb_stb_i,
    input  logic                            wb_cyc_i,
    output logic [DATA_WIDTH-1:0]           wb_rdata_o,
    output logic                            wb_ack_o,
    output logic                            wb_err_o,
    output logic [RAM_ADDR_WIDTH-1:0]       ram_addr_o,
    output logic [DATA_WIDTH-1:0]           ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]         ram_be_o,
    output logic [NUM_BANKS-1:0]            ram_cs_o,
    output logic [NUM_BANKS-1:0]            ram_we_o,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] ram_rdata_i
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = 2;
    // Counter starts at RD_LATENCY-1 so the last WAIT cycle is the data-valid one
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    wb_ram_state_e               state;
    wb_ram_state_e               next_state;
    logic [RAM_ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]       wdata_q;
    logic [DATA_WIDTH-1:0]       rdata_q;
    logic [DATA_WIDTH-1:0]       bank_rdata;
    logic [BE_W-1:0]             sel_q;
    logic                        we_q;
    logic [BANK_SEL_WIDTH-1:0]   bank_q;
    logic [BANK_SEL_WIDTH-1:0]   bank_in;
    logic [CNT_W-1:0]            cnt;
    logic                        req;
    logic                        accept;
    logic                        unused_addr;

    assign req         = wb_cyc_i & wb_stb_i;
    assign bank_in     = wb_addr_i[BANK_SEL_LSB +: BANK_SEL_WIDTH];
    assign accept      = en_i & bank_valid(32'(bank_in), NUM_BANKS);
    // Byte-lane bits and upper address bits outside the bank field carry no meaning here
    assign unused_addr = ^wb_addr_i;

    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign ram_be_o    = sel_q;
    assign wb_rdata_o  = rdata_q;

    // State register
    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= next_state;
    end

    // Next-state decode; dropping cyc aborts REQ/WAIT, ACK/ERR always complete
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req) next_state = accept ? ST_REQ : ST_ERR;
            ST_REQ: begin
                if (!wb_cyc_i)  next_state = ST_IDLE;
                else if (we_q)  next_state = ST_ACK;
                else            next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (!wb_cyc_i)      next_state = ST_IDLE;
                else if (cnt == '0) next_state = ST_ACK;
            end
            ST_ACK:  next_state = ST_IDLE;
            ST_ERR:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Moore outputs: pulses from ACK/ERR, RAM strobes only during REQ
    always_comb begin
        wb_ack_o = (state == ST_ACK);
        wb_err_o = (state == ST_ERR);
        ram_cs_o = '0;
        ram_we_o = '0;
        if (state == ST_REQ) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (bank_q == BANK_SEL_WIDTH'(i)) begin
                    ram_cs_o[i] = 1'b1;
                    ram_we_o[i] = we_q;
                end
            end
        end
    end

    // Capture the request on acceptance; later input changes are ignored
    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            bank_q  <= '0;
        end else if (state == ST_IDLE && req && accept) begin
            addr_q  <= wb_addr_i[RAM_ADDR_WIDTH+1:2];
            wdata_q <= wb_wdata_i;
            sel_q   <= wb_sel_i;
            we_q    <= wb_we_i;
            bank_q  <= bank_in;
        end
    end

    // Read-latency down-counter: loaded in REQ, counts through WAIT, cleared on abort
    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else begin
            case (state)
                ST_REQ:  cnt <= (wb_cyc_i && !we_q) ? CNT_LOAD : '0;
                ST_WAIT: begin
                    if (!wb_cyc_i)      cnt <= '0;
                    else if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Select the read bus slice of the bank that owns the transfer
    always_comb begin
        bank_rdata = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_q == BANK_SEL_WIDTH'(i)) bank_rdata = ram_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Latch read data on the last WAIT cycle; held across errors and writes
    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni)                                             rdata_q <= '0;
        else if (state == ST_WAIT && wb_cyc_i && cnt == '0)      rdata_q <= bank_rdata;
    end

endmodule

// File: tb/tb_wb_ram_bank_ctrl.sv
// Directed bench for wb_ram_bank_ctrl: one instance at read latency 1, one at 3,
// each with its own bus cycle line and a behavioural RAM model.
// Expected values are computed by hand from the address map and write history.
module tb_wb_ram_bank_ctrl;

    localparam logic [31:0] MARK = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        stb = 1'b0;
    logic        cyc1 = 1'b0;
    logic        cyc3 = 1'b0;

    logic [31:0] rdata1, rdata3, rwdata1, rwdata3;
    logic        ack1, ack3, err1, err3;
    logic [10:0] raddr1, raddr3;
    logic [3:0]  be1, be3;
    logic [1:0]  cs1, cs3, rwe1, rwe3;
    logic [63:0] rbus1, rbus3;

    int checks = 0;
    int failures = 0;
    int cyc_no = 0;

    always #5 clk = ~clk;

    wb_ram_bank_ctrl #(.RD_LATENCY(1)) u1 (
        .wb_clk_i(clk), .rst_ni(rst_n), .en_i(en), .wb_addr_i(addr), .wb_wdata_i(wdata),
        .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc1),
        .wb_rdata_o(rdata1), .wb_ack_o(ack1), .wb_err_o(err1),
        .ram_addr_o(raddr1), .ram_wdata_o(rwdata1), .ram_be_o(be1),
        .ram_cs_o(cs1), .ram_we_o(rwe1), .ram_rdata_i(rbus1)
    );

    wb_ram_bank_ctrl #(.RD_LATENCY(3)) u3 (
        .wb_clk_i(clk), .rst_ni(rst_n), .en_i(en), .wb_addr_i(addr), .wb_wdata_i(wdata),
        .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc3),
        .wb_rdata_o(rdata3), .wb_ack_o(ack3), .wb_err_o(err3),
        .ram_addr_o(raddr3), .ram_wdata_o(rwdata3), .ram_be_o(be3),
        .ram_cs_o(cs3), .ram_we_o(rwe3), .ram_rdata_i(rbus3)
    );

    // RAM models: read data is valid only in the one cycle the latency dictates
    logic [31:0] mem1 [2][2048];
    logic [31:0] q1   [2];
    logic [31:0] mem3 [2][2048];
    logic [31:0] p3   [3][2];

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            q1[b] <= MARK;
            if (cs1[b]) begin
                if (rwe1[b]) begin
                    for (int k = 0; k < 4; k++)
                        if (be1[k]) mem1[b][raddr1][8*k +: 8] <= rwdata1[8*k +: 8];
                end else begin
                    q1[b] <= mem1[b][raddr1];
                end
            end
        end
    end
    assign rbus1 = {q1[1], q1[0]};

    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            p3[0][b] <= MARK;
            if (cs3[b]) begin
                if (rwe3[b]) begin
                    for (int k = 0; k < 4; k++)
                        if (be3[k]) mem3[b][raddr3][8*k +: 8] <= rwdata3[8*k +: 8];
                end else begin
                    p3[0][b] <= mem3[b][raddr3];
                end
            end
            p3[1][b] <= p3[0][b];
            p3[2][b] <= p3[1][b];
        end
    end
    assign rbus3 = {p3[2][1], p3[2][0]};

    task automatic chk(input string tag, input bit ok, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    // One Wishbone transfer on the chosen instance; records RAM strobe activity and
    // the absolute cycle of ack/err (-1 on timeout, -2 if ack and err coincide)
    task automatic xfer(input bit d3, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit hold,
                        output int ack_at, output bit is_err, output logic [31:0] rd,
                        output int cs_n, output int cs_at, output logic [1:0] cs_v,
                        output logic [1:0] we_v, output logic [10:0] ad_v,
                        output logic [3:0] be_v, output logic [31:0] wd_v, output bit tail);
        bit done;
        int n;
        addr = a; wdata = d; sel = s; we = w; stb = 1'b1;
        if (d3) cyc3 = 1'b1; else cyc1 = 1'b1;
        ack_at = -1; is_err = 1'b0; rd = '0; cs_n = 0; cs_at = -1;
        cs_v = '0; we_v = '0; ad_v = '0; be_v = '0; wd_v = '0; tail = 1'b0;
        done = 1'b0; n = 0;
        if ((d3 ? cs3 : cs1) != 2'b00) cs_n++;
        while (!done && n < 30) begin
            tick();
            n++;
            if ((d3 ? cs3 : cs1) != 2'b00) begin
                cs_n++;
                cs_at = cyc_no;
                cs_v  = d3 ? cs3 : cs1;
                we_v  = d3 ? rwe3 : rwe1;
                ad_v  = d3 ? raddr3 : raddr1;
                be_v  = d3 ? be3 : be1;
                wd_v  = d3 ? rwdata3 : rwdata1;
            end
            if ((d3 ? ack3 : ack1) || (d3 ? err3 : err1)) begin
                done   = 1'b1;
                ack_at = ((d3 ? ack3 : ack1) && (d3 ? err3 : err1)) ? -2 : cyc_no;
                is_err = d3 ? err3 : err1;
                rd     = d3 ? rdata3 : rdata1;
            end
        end
        if (!hold) begin
            stb = 1'b0; cyc1 = 1'b0; cyc3 = 1'b0;
            tick();
            tail = (d3 ? (ack3 | err3) : (ack1 | err1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_at, ack_at2, cs_n, cs_at, start;
        bit is_err, tail, flag;
        logic [1:0]  csv, wev;
        logic [10:0] adv;
        logic [3:0]  bev;
        logic [31:0] wdv, rd;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp1", {ack1, err1, cs1, rwe1} === 6'b0, {ack1, err1, cs1, rwe1}, 6'b0);
        chk("rst_data1", {rdata1, raddr1, be1, rwdata1} === 79'b0, {rdata1, raddr1, be1, rwdata1}, 79'b0);
        chk("rst_resp3", {ack3, err3, cs3, rwe3} === 6'b0, {ack3, err3, cs3, rwe3}, 6'b0);
        chk("rst_data3", {rdata3, raddr3, be3, rwdata3} === 79'b0, {rdata3, raddr3, be3, rwdata3}, 79'b0);
        rst_n = 1'b1;
        tick();

        // Full write to bank 1 (IRAM)
        start = cyc_no;
        xfer(0, 1, 32'h0000_2010, 32'hDEAD_BEEF, 4'hF, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        chk("wr_ack_cyc", (ack_at - start) === 2, ack_at - start, 2);
        chk("wr_cs_cyc", (cs_at - start) === 1, cs_at - start, 1);
        chk("wr_cs_cnt", cs_n === 1, cs_n, 1);
        chk("wr_cs", csv === 2'b10, csv, 2'b10);
        chk("wr_we", wev === 2'b10, wev, 2'b10);
        chk("wr_addr", adv === 11'h004, adv, 11'h004);
        chk("wr_be", bev === 4'hF, bev, 4'hF);
        chk("wr_wdata", wdv === 32'hDEAD_BEEF, wdv, 32'hDEAD_BEEF);
        chk("wr_ack_one_cycle", tail === 1'b0, tail, 1'b0);

        // Read from bank 0, latency 1
        xfer(0, 1, 32'h0000_0008, 32'h1234_5678, 4'hF, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        start = cyc_no;
        xfer(0, 0, 32'h0000_0008, 32'h0, 4'hF, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        chk("rd1_ack_cyc", (ack_at - start) === 3, ack_at - start, 3);
        chk("rd1_data", rd === 32'h1234_5678, rd, 32'h1234_5678);
        chk("rd1_cs_cnt", cs_n === 1, cs_n, 1);
        chk("rd1_cs", {csv, wev, adv} === {2'b01, 2'b00, 11'h002}, {csv, wev, adv}, {2'b01, 2'b00, 11'h002});
        chk("rd1_err", is_err === 1'b0, is_err, 1'b0);

        // Read from bank 0, latency 3
        xfer(1, 1, 32'h0000_0008, 32'h1234_5678, 4'hF, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        start = cyc_no;
        xfer(1, 0, 32'h0000_0008, 32'h0, 4'hF, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        chk("rd3_ack_cyc", (ack_at - start) === 5, ack_at - start, 5);
        chk("rd3_data", rd === 32'h1234_5678, rd, 32'h1234_5678);
        chk("rd3_ack_one_cycle", tail === 1'b0, tail, 1'b0);

        // Unmapped bank 3
        start = cyc_no;
        xfer(0, 0, 32'h0000_6000, 32'h0, 4'hF, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        chk("unmapped_err_cyc", (ack_at - start) === 1, ack_at - start, 1);
        chk("unmapped_is_err", is_err === 1'b1, is_err, 1'b1);
        chk("unmapped_no_cs", cs_n === 0, cs_n, 0);
        chk("unmapped_rdata_kept", rd === 32'h1234_5678, rd, 32'h1234_5678);
        chk("unmapped_err_one_cycle", tail === 1'b0, tail, 1'b0);

        // Disabled block, valid address
        en = 1'b0;
        start = cyc_no;
        xfer(0, 1, 32'h0000_2010, 32'h0BAD_0BAD, 4'hF, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        chk("disabled_err_cyc", (ack_at - start) === 1, ack_at - start, 1);
        chk("disabled_is_err", is_err === 1'b1, is_err, 1'b1);
        chk("disabled_no_cs", cs_n === 0, cs_n, 0);
        en = 1'b1;

        // Byte write on latency-3 instance: only byte 2 changes
        xfer(1, 1, 32'h0000_000C, 32'h1122_3344, 4'hF, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        start = cyc_no;
        xfer(1, 1, 32'h0000_000C, 32'hAABB_CCDD, 4'b0100, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        chk("bytewr_ack_cyc", (ack_at - start) === 2, ack_at - start, 2);
        chk("bytewr_be", bev === 4'b0100, bev, 4'b0100);
        chk("bytewr_wdata", wdv === 32'hAABB_CCDD, wdv, 32'hAABB_CCDD);
        chk("bytewr_addr", adv === 11'h003, adv, 11'h003);
        xfer(1, 0, 32'h0000_000C, 32'h0, 4'hF, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        chk("bytewr_readback", rd === 32'h11BB_3344, rd, 32'h11BB_3344);

        // Write with no byte selects: strobes still issued, data untouched
        start = cyc_no;
        xfer(1, 1, 32'h0000_000C, 32'h0000_0000, 4'b0000, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        chk("sel0_ack_cyc", (ack_at - start) === 2, ack_at - start, 2);
        chk("sel0_strobes", {csv, wev, bev} === {2'b01, 2'b01, 4'b0000}, {csv, wev, bev}, {2'b01, 2'b01, 4'b0000});
        xfer(1, 0, 32'h0000_000C, 32'h0, 4'hF, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        chk("sel0_readback", rd === 32'h11BB_3344, rd, 32'h11BB_3344);

        // Drop cyc during WAIT on latency-3 instance
        addr = 32'h0000_0008; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc3 = 1'b1;
        tick();
        tick();
        stb = 1'b0; cyc3 = 1'b0;
        flag = 1'b0;
        repeat (6) begin
            tick();
            flag = flag | ack3 | err3 | (|cs3);
        end
        chk("abort_no_ack", flag === 1'b0, flag, 1'b0);
        start = cyc_no;
        xfer(1, 0, 32'h0000_0008, 32'h0, 4'hF, 0, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        chk("abort_next_rd_cyc", (ack_at - start) === 5, ack_at - start, 5);
        chk("abort_next_rd_data", rd === 32'h1234_5678, rd, 32'h1234_5678);

        // Reset pulse during REQ of a write
        addr = 32'h0000_2014; wdata = 32'hCAFE_F00D; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc1 = 1'b1;
        tick();
        chk("rstreq_in_req", cs1 === 2'b10, cs1, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("rstreq_async_resp", {ack1, err1, cs1, rwe1, be1} === 10'b0, {ack1, err1, cs1, rwe1, be1}, 10'b0);
        chk("rstreq_async_data", {raddr1, rwdata1, rdata1} === 75'b0, {raddr1, rwdata1, rdata1}, 75'b0);
        stb = 1'b0; cyc1 = 1'b0;
        tick();
        chk("rstreq_next_cycle", {ack1, err1, cs1, rwe1, be1, raddr1, rwdata1, rdata1} === 85'b0,
            {ack1, err1, cs1, rwe1, be1, raddr1, rwdata1, rdata1}, 85'b0);
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (5) begin
            tick();
            flag = flag | ack1 | err1;
        end
        chk("rstreq_no_late_ack", flag === 1'b0, flag, 1'b0);

        // Back-to-back write then read after reset
        start = cyc_no;
        xfer(0, 1, 32'h0000_2018, 32'h5A5A_A5A5, 4'hF, 1, ack_at, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        xfer(0, 0, 32'h0000_2018, 32'h0, 4'hF, 0, ack_at2, is_err, rd, cs_n, cs_at, csv, wev, adv, bev, wdv, tail);
        chk("b2b_wr_ack_cyc", (ack_at - start) === 2, ack_at - start, 2);
        chk("b2b_rd_spacing", (ack_at2 - ack_at) === 4, ack_at2 - ack_at, 4);
        chk("b2b_rd_data", rd === 32'h5A5A_A5A5, rd, 32'h5A5A_A5A5);
        chk("b2b_rd_bank", {csv, adv} === {2'b10, 11'h006}, {csv, adv}, {2'b10, 11'h006});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
